// File: rtl/bluetooth_cmd_scheduler.sv
// bluetooth_cmd_scheduler: arbitrates host TX requests and periodic RX polls, drives the AT-command encoder, streams the frame bytewise.
//   host:    poll_enable, tx_req/tx_data in; tx_ack out
//   encoder: enc_start, enc_command_select, enc_input_data out; enc_output_data, enc_done (1 = idle) in
//   uart:    byte_data/byte_valid out; byte_ready in
//   status:  busy, cmd_done, err_timeout out; reset is asynchronous active-low
module bluetooth_cmd_scheduler #(
  parameter int POLL_PERIOD = 50000,
  parameter int ENC_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         poll_enable,
  input  logic         tx_req,
  input  logic [31:0]  tx_data,
  output logic         tx_ack,
  output logic         enc_start,
  output logic [3:0]   enc_command_select,
  output logic [31:0]  enc_input_data,
  input  logic [143:0] enc_output_data,
  input  logic         enc_done,
  output logic [7:0]   byte_data,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         cmd_done,
  output logic         err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, SEND} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      data_q, data_d;
  logic [143:0]     buf_q, buf_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d, to_cnt_q, to_cnt_d;
  logic             pending_q, pending_d, last_rx_q, last_rx_d;
  logic             cmd_done_q, cmd_done_d, err_q, err_d;
  logic             wrap, sel_tx, sel_rx, expired, last_byte;
  assign wrap      = poll_enable && poll_cnt_q == CNT_W'(POLL_PERIOD - 1);
  // round-robin: TX wins unless a poll is pending and TX was served last
  assign sel_tx    = state_q == IDLE && tx_req && (!pending_q || last_rx_q);
  assign sel_rx    = state_q == IDLE && pending_q && !sel_tx;
  assign expired   = to_cnt_q == CNT_W'(ENC_TIMEOUT - 1);
  assign last_byte = idx_q == (cmd_q == 4'h1 ? 5'd17 : 5'd12);
  assign tx_ack             = reset && sel_tx;
  assign enc_start          = state_q == ISSUE;
  assign byte_valid         = state_q == SEND;
  assign busy               = state_q != IDLE;
  assign enc_command_select = cmd_q;
  assign enc_input_data     = data_q;
  assign byte_data          = 8'(buf_q >> {idx_q, 3'b000});
  assign cmd_done           = cmd_done_q;
  assign err_timeout        = err_q;
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    last_rx_d  = last_rx_q;
    cmd_done_d = 1'b0;
    err_d      = 1'b0;
    poll_cnt_d = (!poll_enable || wrap) ? '0 : poll_cnt_q + 1'b1;
    // a poll expiry coinciding with RX selection is absorbed
    pending_d  = !sel_rx && (pending_q || wrap);
    case (state_q)
      IDLE: if (sel_tx || sel_rx) begin
        state_d   = ISSUE;
        cmd_d     = sel_tx ? 4'h1 : 4'h2;
        data_d    = sel_tx ? tx_data : '0;
        last_rx_d = sel_rx;
        to_cnt_d  = '0;
      end
      ISSUE, WAIT_DONE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == WAIT_DONE && enc_done) begin
          state_d = SEND;
          buf_d   = enc_output_data;
          idx_d   = '0;
        end else if (expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (state_q == ISSUE && !enc_done) state_d = WAIT_DONE;
      end
      default: if (byte_ready) begin
        state_d    = last_byte ? IDLE : SEND;
        idx_d      = last_byte ? '0 : idx_q + 5'd1;
        cmd_done_d = last_byte;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      pending_q  <= 1'b0;
      last_rx_q  <= 1'b1;
      cmd_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      pending_q  <= pending_d;
      last_rx_q  <= last_rx_d;
      cmd_done_q <= cmd_done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_bluetooth_cmd_scheduler.sv
// tb_bluetooth_cmd_scheduler: randomized bench with a transaction-level scheduler model and a behavioural encoder responder.
module tb_bluetooth_cmd_scheduler;
  localparam int P = 10;
  localparam int T = 8;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         poll_enable = 1'b0, tx_req = 1'b0, tx_ack;
  logic [31:0]  tx_data = '0;
  logic         enc_start, enc_done = 1'b1;
  logic [3:0]   enc_command_select;
  logic [31:0]  enc_input_data;
  logic [143:0] enc_output_data = '0;
  logic [7:0]   byte_data;
  logic         byte_valid, byte_ready = 1'b1, busy, cmd_done, err_timeout;
  always #5 clk = ~clk;
  bluetooth_cmd_scheduler #(.POLL_PERIOD(P), .ENC_TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .poll_enable(poll_enable), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ack(tx_ack), .enc_start(enc_start), .enc_command_select(enc_command_select),
    .enc_input_data(enc_input_data), .enc_output_data(enc_output_data), .enc_done(enc_done),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .cmd_done(cmd_done), .err_timeout(err_timeout)
  );
  int vectors = 0, miscompares = 0;
  logic [7:0] tx_lit [18] = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52,
                              8'h54, 8'h54, 8'h58, 8'h3D, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
  logic [7:0] rx_lit [13] = '{8'h41, 8'h54, 8'h2B, 8'h42, 8'h4C, 8'h45, 8'h55, 8'h41, 8'h52,
                              8'h54, 8'h52, 8'h58, 8'h0D};
  // scheduler model: phase 0 idle, 1 start issued, 2 encoder running, 3 streaming
  int         m_phase, m_poll, m_age, n_done = 0, n_to = 0;
  bit         m_pend, m_last_rx, m_cd, m_err, m_ack_prev;
  logic [3:0] m_cmd;
  logic [31:0] m_data;
  logic [7:0] exp_q[$], cur_bytes[$], last_bytes[$];
  int         served[$];
  // stimulus controls
  int         tx_auto = 0, ready_mode = 0, hang_mode = 0, pcnt = 0;
  bit         poll_en_next = 1'b0, dir_req = 1'b0, enc_fixed = 1'b1;
  logic [31:0] dir_data;
  // encoder responder
  int         e_st = 0, e_cnt = 0;
  logic [3:0] e_cmd;
  logic [31:0] e_dat;
  bit         prev_start = 1'b0;
  int         k, j, base;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [143:0] frame(input logic [3:0] c, input logic [31:0] d);
    string s;
    logic [143:0] f;
    f = '0;
    if (c == 4'h1) s = "AT+BLEUARTTX=";
    else s = "AT+BLEUARTRX";
    for (int i = 0; i < s.len(); i++) f[8*i +: 8] = s[i];
    if (c == 4'h1) begin
      f[104 +: 32] = d;
      f[136 +: 8] = 8'h0D;
    end else f[96 +: 8] = 8'h0D;
    return f;
  endfunction
  function automatic bit m_sel_tx();
    return m_phase == 0 && tx_req && (!m_pend || m_last_rx);
  endfunction
  task automatic m_reset();
    m_phase = 0; m_poll = 0; m_age = 0; m_pend = 0; m_last_rx = 1;
    m_cd = 0; m_err = 0; m_ack_prev = 0;
    exp_q.delete(); cur_bytes.delete();
    e_st = 0; e_cnt = 0; prev_start = 0; enc_done = 1'b1;
    tx_req = 1'b0; dir_req = 1'b0;
  endtask
  task automatic enc_step();
    bit rise;
    logic [143:0] f;
    rise = enc_start && !prev_start;
    prev_start = enc_start;
    if (e_st == 0 && rise && !(hang_mode == 1 || (hang_mode == 2 && $urandom % 8 == 0))) begin
      e_cmd = enc_command_select;
      e_dat = enc_input_data;
      e_st = 1;
      e_cnt = enc_fixed ? 0 : int'($urandom_range(2, 0));
    end
    if (e_st == 1) begin
      if (e_cnt == 0) begin
        e_st = 2;
        e_cnt = enc_fixed ? 3 : int'($urandom_range(3, 1));
      end else e_cnt--;
    end
    if (e_st == 2) begin
      if (e_cnt == 0) begin
        e_st = 0;
        f = frame(e_cmd, e_dat);
        enc_output_data = f;
      end else e_cnt--;
    end
    if (e_st != 0) enc_output_data = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
    enc_done = e_st != 2;
  endtask
  task automatic compare();
    chk("busy", busy, m_phase != 0);
    chk("tx_ack", tx_ack, m_sel_tx());
    chk("enc_start", enc_start, m_phase == 1);
    chk("byte_valid", byte_valid, m_phase == 3);
    chk("cmd_done", cmd_done, m_cd);
    chk("err_timeout", err_timeout, m_err);
    if (m_phase == 1 || m_phase == 2) begin
      chk("enc_command_select", enc_command_select, m_cmd);
      chk("enc_input_data", enc_input_data, m_data);
    end
    if (m_phase == 3 && exp_q.size() > 0) chk("byte_data", byte_data, exp_q[0]);
  endtask
  task automatic step();
    bit wrap, seltx, selrx;
    logic [143:0] f;
    wrap = poll_enable && m_poll == P - 1;
    seltx = m_sel_tx();
    selrx = m_phase == 0 && m_pend && !seltx;
    m_ack_prev = seltx;
    m_cd = 0;
    m_err = 0;
    m_pend = selrx ? 1'b0 : (m_pend || wrap);
    m_poll = (!poll_enable || wrap) ? 0 : m_poll + 1;
    case (m_phase)
      0: if (seltx || selrx) begin
        m_cmd = seltx ? 4'h1 : 4'h2;
        m_data = seltx ? tx_data : 32'h0;
        m_last_rx = selrx;
        m_phase = 1;
        m_age = 0;
        served.push_back(int'(m_cmd));
      end
      1, 2: begin
        m_age++;
        if (m_phase == 2 && enc_done) begin
          f = frame(m_cmd, m_data);
          for (int i = 0; i < (m_cmd == 4'h1 ? 18 : 13); i++) exp_q.push_back(f[8*i +: 8]);
          cur_bytes.delete();
          m_phase = 3;
        end else if (m_age == T) begin
          m_err = 1;
          m_phase = 0;
          n_to++;
        end else if (m_phase == 1 && !enc_done) m_phase = 2;
      end
      default: if (byte_ready) begin
        cur_bytes.push_back(byte_data);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_cd = 1;
          m_phase = 0;
          last_bytes = cur_bytes;
          n_done++;
        end
      end
    endcase
  endtask
  task automatic cycle_body();
    enc_step();
    if (m_ack_prev) tx_req = 1'b0;
    if (!tx_req && dir_req) begin
      tx_req = 1'b1;
      tx_data = dir_data;
      dir_req = 1'b0;
    end else if (!tx_req && tx_auto > 0 && $urandom % tx_auto == 0) begin
      tx_req = 1'b1;
      tx_data = $urandom;
    end else if (!tx_req) tx_data = $urandom;
    byte_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (pcnt % 4 == 0 || pcnt % 4 == 3) : 1'($urandom % 2);
    pcnt++;
    poll_enable = poll_en_next;
    #1;
    compare();
    step();
  endtask
  task automatic cycle();
    @(negedge clk);
    cycle_body();
  endtask
  task automatic run_until(input string n, input bit to, input int tgt, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if ((to ? n_to : n_done) >= tgt) break;
      cycle();
    end
    chk(n, (to ? n_to : n_done) >= tgt, 1'b1);
  endtask
  task automatic drain();
    poll_en_next = 1'b0;
    tx_auto = 0;
    repeat (80) cycle();
    chk("drain_idle", busy, 1'b0);
  endtask
  task automatic check_tx_frame(input string n);
    chk(n, last_bytes.size(), 18);
    for (int i = 0; i < 18; i++) chk(n, (i < last_bytes.size()) ? last_bytes[i] : 8'hxx, tx_lit[i]);
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_ack", tx_ack, 1'b0);
    chk("rst_enc_start", enc_start, 1'b0);
    chk("rst_select", enc_command_select, 4'h0);
    chk("rst_input_data", enc_input_data, 32'h0);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_data", byte_data, 8'h0);
    chk("rst_cmd_done", cmd_done, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cycle_body();
    // single TX, fixed 3-cycle encoder
    dir_data = 32'h44434241;
    dir_req = 1'b1;
    run_until("tx_only_done", 1'b0, 1, 60);
    check_tx_frame("tx_only_bytes");
    // RX poll timing and frame
    poll_en_next = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (!enc_start && k < 40);
    chk("poll_issue_delay", k, 12);
    chk("poll_select", enc_command_select, 4'h2);
    run_until("rx_done", 1'b0, n_done + 1, 60);
    chk("rx_len", last_bytes.size(), 13);
    for (int i = 0; i < 13; i++) chk("rx_bytes", (i < last_bytes.size()) ? last_bytes[i] : 8'hxx, rx_lit[i]);
    drain();
    // both sources always pending: strict alternation
    base = served.size();
    tx_auto = 1;
    poll_en_next = 1'b1;
    enc_fixed = 1'b0;
    run_until("rr_done", 1'b0, n_done + 4, 400);
    for (int i = 0; i < 4; i++) chk("rr_order", (base + i < served.size()) ? served[base + i] : 0, (i % 2 == 0) ? 1 : 2);
    drain();
    // stalled UART
    ready_mode = 1;
    dir_data = 32'h44434241;
    dir_req = 1'b1;
    run_until("stall_done", 1'b0, n_done + 1, 200);
    check_tx_frame("stall_bytes");
    ready_mode = 0;
    // encoder never goes busy
    hang_mode = 1;
    dir_data = $urandom;
    dir_req = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (!enc_start && k < 20);
    j = 0;
    do begin cycle(); j++; end while (!err_timeout && j < 40);
    chk("timeout_delay", j, T);
    hang_mode = 0;
    dir_data = $urandom;
    dir_req = 1'b1;
    run_until("after_timeout_done", 1'b0, n_done + 1, 80);
    drain();
    // reset in the middle of a frame
    poll_en_next = 1'b1;
    dir_data = $urandom;
    dir_req = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (!(m_phase == 3 && cur_bytes.size() == 5) && k < 80);
    chk("reach_idx5", m_phase == 3 && cur_bytes.size() == 5, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_byte_valid", byte_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle_body();
    k = 1;
    while (!enc_start && k < 40) begin cycle(); k++; end
    chk("poll_restart_delay", k, 12);
    run_until("post_rst_rx", 1'b0, n_done + 1, 80);
    drain();
    dir_data = 32'h44434241;
    dir_req = 1'b1;
    run_until("post_rst_tx", 1'b0, n_done + 1, 80);
    check_tx_frame("post_rst_bytes");
    // randomized traffic
    base = n_done;
    tx_auto = 3;
    ready_mode = 2;
    hang_mode = 2;
    poll_en_next = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 100 == 0) poll_en_next = !poll_en_next;
      cycle();
    end
    chk("random_progress", n_done - base >= 20, 1'b1);
    chk("random_timeouts_seen", n_to >= 2, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
